// File: rtl/picobus_pkg.sv
// Shared PicoBus128 constants, arbiter state encoding and the alignment helper.
package picobus_pkg;

  localparam int PICOBUS_ADDR_W = 32;
  localparam int PICOBUS_DATA_W = 128;
  localparam logic [3:0] PICOBUS_ALIGN_MASK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } pb_state_e;

  // Registers sit on 16-byte boundaries; any low nibble bit set is a misaligned access.
  function automatic logic pb_aligned(input logic [3:0] addr_lsb);
    return (addr_lsb & PICOBUS_ALIGN_MASK) == 4'h0;
  endfunction

endpackage

// File: rtl/picobus_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod N_REQ.
module picobus_rr_pick
  import picobus_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [PTR_W-1:0] win_idx_o,
  output logic             any_o
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(ptr_i) + k) % N_REQ);
      if (!any_o && req_i[cand]) begin
        any_o           = 1'b1;
        win_idx_o       = cand;
        win_oh_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/picobus_req_arbiter.sv
// Round-robin arbiter sharing one PicoBus128 register-bank port among N_REQ requesters,
// one transaction in flight, fixed read latency, with a completed-transaction counter.
module picobus_req_arbiter
  import picobus_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = PICOBUS_ADDR_W,
  parameter int DATA_W = PICOBUS_DATA_W
) (
  input  logic                     PicoClk,
  input  logic                     PicoRst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_gnt,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     addr_err,
  output logic                     bus_rd,
  output logic                     bus_wr,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic [DATA_W-1:0]        bus_rdata,
  output logic [31:0]              xact_cnt
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int LAT_W = $clog2(RD_LAT) + 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  pb_state_e          state_q;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [LAT_W-1:0]   lat_q;
  logic [N_REQ-1:0]   win_oh_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               addr_err_q;
  logic               bus_rd_q;
  logic               bus_wr_q;
  logic [ADDR_W-1:0]  bus_addr_q;
  logic [DATA_W-1:0]  bus_wdata_q;
  logic [31:0]        xact_q;

  logic [N_REQ-1:0]   pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_aligned;

  picobus_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign sel_we      = req_we[pick_idx];
  assign sel_addr    = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata   = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
  assign sel_aligned = pb_aligned(sel_addr[3:0]);
  assign ptr_d       = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + PTR_W'(1);

  // Strobe-type outputs default low each cycle; the IDLE winner arms them so they
  // are visible exactly during the ISSUE cycle.
  always_ff @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lat_q       <= '0;
      win_oh_q    <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      addr_err_q  <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      xact_q      <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      addr_err_q  <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            win_oh_q <= pick_oh;
            ptr_q    <= ptr_d;
            gnt_q    <= pick_oh;
            state_q  <= ISSUE;
            if (!sel_aligned) begin
              addr_err_q <= 1'b1;
            end else if (sel_we) begin
              bus_wr_q    <= 1'b1;
              bus_addr_q  <= sel_addr;
              bus_wdata_q <= sel_wdata;
            end else begin
              bus_rd_q   <= 1'b1;
              bus_addr_q <= sel_addr;
            end
          end
        end
        ISSUE: begin
          lat_q <= '0;
          if (bus_rd_q) begin
            state_q <= WAIT_RD;
          end else begin
            state_q <= IDLE;
            if (bus_wr_q) xact_q <= xact_q + 32'd1;
          end
        end
        WAIT_RD: begin
          if (lat_q == LAT_LAST) begin
            rsp_rdata_q <= bus_rdata;
            rsp_valid_q <= win_oh_q;
            xact_q      <= xact_q + 32'd1;
            state_q     <= IDLE;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_gnt   = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign addr_err  = addr_err_q;
  assign bus_rd    = bus_rd_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign xact_cnt  = xact_q;

endmodule

// File: tb/tb_picobus_req_arbiter.sv
// Scoreboard bench for picobus_req_arbiter with a 4 x 128-bit register-file bus model.
module tb_picobus_req_arbiter;

  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  localparam logic [127:0] R0  = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A0;
  localparam logic [127:0] R1  = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00B1;
  localparam logic [127:0] R2  = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00C2;
  localparam logic [127:0] R3  = 128'h0123_4567_89AB_CDEF_0000_0000_0000_00D3;
  localparam logic [127:0] W30 = 128'hCAFE_0000_0000_0000_0000_0000_1234_5678;

  logic              PicoClk = 1'b0;
  logic              PicoRst_n;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_gnt;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              addr_err;
  logic              bus_rd;
  logic              bus_wr;
  logic [AW-1:0]     bus_addr;
  logic [DW-1:0]     bus_wdata;
  logic [DW-1:0]     bus_rdata;
  logic [31:0]       xact_cnt;

  picobus_req_arbiter #(
    .N_REQ  (N),
    .RD_LAT (1),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .PicoClk   (PicoClk),
    .PicoRst_n (PicoRst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_gnt   (req_gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .addr_err  (addr_err),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .xact_cnt  (xact_cnt)
  );

  always #5 PicoClk = ~PicoClk;

  int cyc = 0;
  always @(posedge PicoClk) cyc <= cyc + 1;

  // Register-file bus model, one-cycle read latency.
  logic         model_init = 1'b1;
  logic [127:0] regs [4];
  always @(posedge PicoClk) begin
    if (model_init) begin
      regs[0] <= R0;
      regs[1] <= R1;
      regs[2] <= R2;
      regs[3] <= R3;
    end else if (bus_wr) begin
      regs[bus_addr[5:4]] <= bus_wdata;
    end
    if (bus_rd) bus_rdata <= regs[bus_addr[5:4]];
  end

  typedef struct {
    int           cyc;
    logic [3:0]   oh;
    logic         wr;
    logic         rd;
    logic         err;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } gexp_t;

  typedef struct {
    int           cyc;
    logic [3:0]   oh;
    logic [127:0] rdata;
  } rexp_t;

  typedef struct {
    int          cyc;
    logic [31:0] xact;
    bit          zero;
  } sexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  sexp_t sq[$];

  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;
  bit mon_done = 1'b0;
  logic [N-1:0] keep = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic exp_gnt(input int c, input logic [3:0] oh, input logic wr, input logic rd,
                         input logic err, input logic [31:0] a, input logic [127:0] d);
    gexp_t e;
    e.cyc = c; e.oh = oh; e.wr = wr; e.rd = rd; e.err = err; e.addr = a; e.wdata = d;
    gq.push_back(e);
  endtask

  task automatic exp_rsp(input int c, input logic [3:0] oh, input logic [127:0] d);
    rexp_t e;
    e.cyc = c; e.oh = oh; e.rdata = d;
    rq.push_back(e);
  endtask

  task automatic exp_status(input int c, input logic [31:0] x, input bit z);
    sexp_t e;
    e.cyc = c; e.xact = x; e.zero = z;
    sq.push_back(e);
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [127:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Requesters release their request on grant unless marked as continuous.
  task automatic tick();
    @(negedge PicoClk);
    req_valid = req_valid & ~(req_gnt & ~keep);
  endtask

  // Monitor: pops and compares whenever the DUT presents a grant or response.
  initial begin
    gexp_t g;
    rexp_t r;
    sexp_t s;
    forever begin
      @(negedge PicoClk);
      chk("rd_wr_exclusive", 128'(bus_rd & bus_wr), 128'd0);
      if (req_gnt != '0) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 128'(req_gnt), 128'd0);
        end else begin
          g = gq.pop_front();
          chk("gnt_cycle", 128'(cyc), 128'(g.cyc));
          chk("gnt_onehot", 128'(req_gnt), 128'(g.oh));
          chk("gnt_bus_wr", 128'(bus_wr), 128'(g.wr));
          chk("gnt_bus_rd", 128'(bus_rd), 128'(g.rd));
          chk("gnt_addr_err", 128'(addr_err), 128'(g.err));
          if (g.wr || g.rd) chk("gnt_bus_addr", 128'(bus_addr), 128'(g.addr));
          if (g.wr) chk("gnt_bus_wdata", bus_wdata, g.wdata);
        end
      end else begin
        chk("strobe_without_gnt", 128'({bus_wr, bus_rd, addr_err}), 128'd0);
        if (gq.size() > 0 && gq[0].cyc < cyc) begin
          g = gq.pop_front();
          chk("gnt_missing", 128'(req_gnt), 128'(g.oh));
        end
      end
      if (rsp_valid != '0) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 128'(rsp_valid), 128'd0);
        end else begin
          r = rq.pop_front();
          chk("rsp_cycle", 128'(cyc), 128'(r.cyc));
          chk("rsp_onehot", 128'(rsp_valid), 128'(r.oh));
          chk("rsp_rdata", rsp_rdata, r.rdata);
        end
      end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
        r = rq.pop_front();
        chk("rsp_missing", 128'(rsp_valid), 128'(r.oh));
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        s = sq.pop_front();
        chk("xact_cnt", 128'(xact_cnt), 128'(s.xact));
        if (s.zero) begin
          chk("zero_gnt", 128'(req_gnt), 128'd0);
          chk("zero_rsp_valid", 128'(rsp_valid), 128'd0);
          chk("zero_rsp_rdata", rsp_rdata, 128'd0);
          chk("zero_strobes", 128'({bus_wr, bus_rd, addr_err}), 128'd0);
          chk("zero_bus_addr", 128'(bus_addr), 128'd0);
          chk("zero_bus_wdata", bus_wdata, 128'd0);
        end
      end
      if (done && !mon_done) begin
        chk("gnt_queue_drained", 128'(gq.size()), 128'd0);
        chk("rsp_queue_drained", 128'(rq.size()), 128'd0);
        chk("status_queue_drained", 128'(sq.size()), 128'd0);
        mon_done = 1'b1;
      end
    end
  end

  initial begin
    repeat (2000) @(posedge PicoClk);
    $display("FAIL watchdog: bench did not complete within 2000 cycles");
    $fatal(1);
  end

  initial begin
    int c;
    logic [127:0] rd_exp [3];
    rd_exp[0] = R0;
    rd_exp[1] = 128'h60;
    rd_exp[2] = R2;

    PicoRst_n  = 1'b0;
    model_init = 1'b1;
    repeat (3) tick();
    c = cyc;
    exp_status(c + 1, 32'd0, 1'b1);
    tick();
    PicoRst_n  = 1'b1;
    model_init = 1'b0;
    c = cyc;
    for (int k = 1; k <= 10; k++) exp_status(c + k, 32'd0, 1'b1);
    repeat (10) tick();

    // Single write from requester 0.
    c = cyc;
    set_req(0, 1'b1, 32'h10, 128'h60);
    exp_gnt(c + 1, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h10, 128'h60);
    exp_status(c + 2, 32'd1, 1'b0);
    repeat (3) tick();

    // Requester 1 reads back the written register.
    c = cyc;
    set_req(1, 1'b0, 32'h10, 128'h0);
    exp_gnt(c + 1, 4'b0010, 1'b0, 1'b1, 1'b0, 32'h10, 128'h0);
    exp_rsp(c + 3, 4'b0010, 128'h60);
    exp_status(c + 3, 32'd2, 1'b0);
    repeat (4) tick();

    // Misaligned read from requester 3 is dropped; pointer wraps to 0.
    c = cyc;
    set_req(3, 1'b0, 32'h14, 128'h0);
    exp_gnt(c + 1, 4'b1000, 1'b0, 1'b0, 1'b1, 32'h0, 128'h0);
    exp_status(c + 2, 32'd2, 1'b0);
    exp_status(c + 3, 32'd2, 1'b0);
    repeat (3) tick();

    // Requesters 0..2 read continuously for nine grants.
    c = cyc;
    keep = 4'b0111;
    set_req(0, 1'b0, 32'h00, 128'h0);
    set_req(1, 1'b0, 32'h10, 128'h0);
    set_req(2, 1'b0, 32'h20, 128'h0);
    for (int n = 0; n < 9; n++) begin
      exp_gnt(c + 1 + 3*n, 4'(1 << (n % 3)), 1'b0, 1'b1, 1'b0, 32'((n % 3) * 16), 128'h0);
      exp_rsp(c + 3 + 3*n, 4'(1 << (n % 3)), rd_exp[n % 3]);
    end
    exp_status(c + 27, 32'd11, 1'b0);
    while (cyc < c + 25) tick();
    req_valid = '0;
    keep      = '0;
    repeat (4) tick();

    // Simultaneous write (req 0) and read (req 1) of 0x30: write wins, read sees it.
    c = cyc;
    set_req(0, 1'b1, 32'h30, W30);
    set_req(1, 1'b0, 32'h30, 128'h0);
    exp_gnt(c + 1, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h30, W30);
    exp_gnt(c + 3, 4'b0010, 1'b0, 1'b1, 1'b0, 32'h30, 128'h0);
    exp_rsp(c + 5, 4'b0010, W30);
    exp_status(c + 2, 32'd12, 1'b0);
    exp_status(c + 5, 32'd13, 1'b0);
    repeat (6) tick();

    // Reset asserted while requester 2's read is in WAIT_RD.
    c = cyc;
    set_req(2, 1'b0, 32'h20, 128'h0);
    exp_gnt(c + 1, 4'b0100, 1'b0, 1'b1, 1'b0, 32'h20, 128'h0);
    for (int k = 2; k <= 7; k++) exp_status(c + k, 32'd0, 1'b1);
    tick();
    @(posedge PicoClk);
    #1;
    PicoRst_n = 1'b0;
    repeat (3) tick();
    PicoRst_n = 1'b1;
    repeat (3) tick();

    // After reset the pointer is 0, so requester 0 beats requester 3.
    c = cyc;
    set_req(0, 1'b0, 32'h00, 128'h0);
    set_req(3, 1'b0, 32'h30, 128'h0);
    exp_gnt(c + 1, 4'b0001, 1'b0, 1'b1, 1'b0, 32'h00, 128'h0);
    exp_rsp(c + 3, 4'b0001, R0);
    exp_gnt(c + 4, 4'b1000, 1'b0, 1'b1, 1'b0, 32'h30, 128'h0);
    exp_rsp(c + 6, 4'b1000, W30);
    exp_status(c + 6, 32'd2, 1'b0);
    repeat (9) tick();

    done = 1'b1;
    wait (mon_done);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
